pwl_batch_framer: RTL
=====================

Name: pwl_batch_framer

Overview:
- Sits directly downstream of pwl_generator and consumes its batch_out / valid_batch_out stream plus pwl_wave_period / valid_pwl_wave_period.
- Buffers batches in a FIFO so they can cross into a backpressured consumer (DAC interface or capture path).
- Tags each batch with first-of-period and last-of-period markers.
- Counts completed wave periods and flags overflow, because pwl_generator has no ready input.

Parameters:
SAMPLE_WIDTH, 16, bits per sample
BATCH_SIZE, 16, samples per batch
PWL_PERIOD_WIDTH, 32, width of the period length (in batches)
FIFO_DEPTH, 16, batch entries buffered; power of 2, at least 2
COUNT_WIDTH, 32, width of period_count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
clear  in  1  synchronous clear of FIFO, framing index, period_count and overflow
batch_in  in  BATCH_SIZE*SAMPLE_WIDTH  batch from pwl_generator
valid_batch_in  in  1  batch_in valid, one batch per cycle, no backpressure
pwl_wave_period  in  PWL_PERIOD_WIDTH  batches per wave period
valid_pwl_wave_period  in  1  period value valid
batch_out  out  BATCH_SIZE*SAMPLE_WIDTH  buffered batch
batch_valid  out  1  batch_out valid
batch_ready  in  1  consumer ready
batch_first  out  1  batch_out is index 0 of its period
batch_last  out  1  batch_out is the final batch of its period
period_count  out  COUNT_WIDTH  periods fully delivered
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held, including the output register
overflow  out  1  sticky: a batch was dropped

Behaviour:
Reset (rst low, asynchronous):
- All outputs go to 0 immediately: batch_out, batch_valid, batch_first, batch_last, period_count, fifo_count, overflow.
- Framing index goes to 0 and the latched period goes to 0.

clear (high at a clock edge):
- Same effect as reset, applied on that edge.
- Overrides every other event in the same cycle; a batch presented in that cycle is discarded.

Framing:
- idx counts every valid_batch_in cycle, including dropped batches, so tags stay aligned to the generator.
- When idx == 0 and valid_batch_in is high, pwl_wave_period is latched as P. P = 0 is treated as 1.
- A batch's tags: first = (idx == 0); last = (idx == P-1). idx then wraps to 0 after P-1, otherwise increments.
- While valid_pwl_wave_period is low: idx is held at 0, and arriving batches are still buffered with first = last = 0.
- A period value change while valid takes effect only at the next idx == 0.

FIFO (stores {data, first, last}):
- Write when valid_batch_in is high.
- Full and no read in the same cycle: the batch is dropped, overflow is set and held until reset/clear, and the FIFO contents are unchanged.
- Full with a simultaneous read: the write is accepted and there is no overflow.
- Output is a registered first-word-fall-through stage. On an empty FIFO, a batch written at edge N drives batch_valid = 1 after edge N; latency is 1 cycle.
- Handshake:
  - A transfer occurs when batch_valid && batch_ready.
  - batch_out, batch_first and batch_last stay stable while batch_valid && !batch_ready.
  - batch_valid never drops without a transfer, except on reset/clear.
- Throughput is 1 batch per cycle with batch_ready held high; there are no bubbles.
- fifo_count is updated every edge: +1 on accepted write, -1 on transfer, unchanged when both occur.

period_count:
- Increments on each transfer with batch_last = 1.
- Saturates at all-ones.

Test Plan:
1. P = 1, 5 batches (distinct ramps), batch_ready = 1 -> 5 outputs in order, each 1 cycle after input, all with first = last = 1; period_count = 5; overflow = 0.
2. P = 3, 9 back-to-back batches -> first on outputs 0, 3, 6; last on outputs 2, 5, 8; period_count = 3; fifo_count returns to 0.
3. P = 4, batch_ready = 0, 20 batches -> fifo_count = 16; overflow rises on the 17th input. Then batch_ready = 1 -> exactly batches 0–15 emerge unchanged. The next input (21st, idx 0) is tagged first = 1.
4. FIFO full, then valid_batch_in and batch_ready both high for 8 cycles -> no overflow, fifo_count stays at 16, output order preserved.
5. rst low mid-stream, asynchronous between edges -> batch_valid, period_count and fifo_count are 0 before the next edge. After release, the first batch is tagged first = 1.
6. valid_pwl_wave_period = 0 with 3 batches, then valid with P = 2 -> the 3 batches have first = last = 0 and no period_count change; subsequent batches alternate first/last; clear pulse -> all counters 0.

Source files
------------

// File: rtl/pwl_batch_framer.sv
// pwl_batch_framer: buffers pwl_generator batches into a backpressured stream tagged with period first/last markers
//   clk, rst (async, active-low)      clock and reset
//   clear                             sync clear of FIFO, framing index, period_count, overflow
//   batch_in, valid_batch_in          generator batch stream, no backpressure
//   pwl_wave_period, valid_*          batches per wave period
//   batch_out, batch_valid,
//   batch_ready, batch_first,
//   batch_last                        registered FWFT output with handshake and period tags
//   period_count                      saturating count of periods fully delivered
//   fifo_count                        entries held, output register included
//   overflow                          sticky, a batch was dropped on a full FIFO
module pwl_batch_framer #(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int BATCH_SIZE       = 16,
    parameter int PWL_PERIOD_WIDTH = 32,
    parameter int FIFO_DEPTH       = 16,
    parameter int COUNT_WIDTH      = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic [BATCH_SIZE*SAMPLE_WIDTH-1:0]   batch_in,
    input  logic                                 valid_batch_in,
    input  logic [PWL_PERIOD_WIDTH-1:0]          pwl_wave_period,
    input  logic                                 valid_pwl_wave_period,
    output logic [BATCH_SIZE*SAMPLE_WIDTH-1:0]   batch_out,
    output logic                                 batch_valid,
    input  logic                                 batch_ready,
    output logic                                 batch_first,
    output logic                                 batch_last,
    output logic [COUNT_WIDTH-1:0]               period_count,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
    output logic                                 overflow
);
    localparam int BW = BATCH_SIZE * SAMPLE_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PWL_PERIOD_WIDTH-1:0] P_ONE = 1;

    logic [BW+1:0]               mem [FIFO_DEPTH];
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [PWL_PERIOD_WIDTH-1:0] idx, p_q, eff_p;
    logic [CW-1:0]               mem_cnt;
    logic tag_first, tag_last, xfer, full, wr_ok, load, from_mem, mem_wr;

    // The period is sampled only at idx 0, so mid-period changes wait for the next period.
    assign eff_p     = (idx == '0) ? ((pwl_wave_period == '0) ? P_ONE : pwl_wave_period) : p_q;
    assign tag_first = valid_pwl_wave_period && idx == '0;
    assign tag_last  = valid_pwl_wave_period && idx == eff_p - P_ONE;
    assign xfer      = batch_valid && batch_ready;
    assign full      = fifo_count == CW'(FIFO_DEPTH);
    assign wr_ok     = valid_batch_in && (!full || xfer);
    assign load      = !batch_valid || xfer;
    // fifo_count includes the output register; the memory holds the rest.
    assign mem_cnt   = fifo_count - CW'(batch_valid);
    assign from_mem  = load && mem_cnt != '0;
    // With an empty memory, a batch arriving as the output frees bypasses straight into it.
    assign mem_wr    = wr_ok && !(load && mem_cnt == '0);

    always_ff @(posedge clk)
        if (rst && !clear && mem_wr)
            mem[wr_ptr] <= {batch_in, tag_first, tag_last};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx          <= '0;
            p_q          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            batch_out    <= '0;
            batch_valid  <= 1'b0;
            batch_first  <= 1'b0;
            batch_last   <= 1'b0;
            period_count <= '0;
            overflow     <= 1'b0;
        end else if (clear) begin
            idx          <= '0;
            p_q          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            batch_out    <= '0;
            batch_valid  <= 1'b0;
            batch_first  <= 1'b0;
            batch_last   <= 1'b0;
            period_count <= '0;
            overflow     <= 1'b0;
        end else begin
            // idx advances on every arriving batch, dropped ones included, to stay aligned with the generator.
            if (valid_batch_in) begin
                if (idx == '0)
                    p_q <= eff_p;
                idx <= (!valid_pwl_wave_period || tag_last) ? '0 : idx + P_ONE;
            end
            if (valid_batch_in && !wr_ok)
                overflow <= 1'b1;
            fifo_count <= fifo_count + CW'(wr_ok) - CW'(xfer);
            if (mem_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (from_mem)
                rd_ptr <= rd_ptr + AW'(1);
            if (load) begin
                batch_valid <= from_mem || wr_ok;
                if (from_mem)
                    {batch_out, batch_first, batch_last} <= mem[rd_ptr];
                else if (wr_ok)
                    {batch_out, batch_first, batch_last} <= {batch_in, tag_first, tag_last};
            end
            if (xfer && batch_last && period_count != '1)
                period_count <= period_count + COUNT_WIDTH'(1);
        end
    end
endmodule
